// File: rtl/frame_pkg.sv
// Shared types and constants for the camera frame FIFO reader.
package frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_WRST,
    S_CAPT,
    S_RRST,
    S_RD_HI,
    S_RD_LO,
    S_EMIT,
    S_TRL0,
    S_TRL1,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    G_IDLE,
    G_HI,
    G_LO
  } rclk_phase_e;

  localparam int unsigned VSYNC_SYNC_DEPTH = 2;
  localparam logic [7:0]  TRAILER_CR       = 8'h0D;
  localparam logic [7:0]  TRAILER_LF       = 8'h0A;

endpackage

// File: rtl/frame_fifo_reader_rclk.sv
// fifo_rclk_gen: emits one read-clock pulse (RCLK_HALF high, RCLK_HALF low) per start.
// start_i on the last low cycle chains the next pulse with no idle gap.
module fifo_rclk_gen
  import frame_pkg::*;
#(
  parameter int unsigned RCLK_HALF = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic rclk_o,
  output logic hi_last_o,
  output logic lo_last_o
);

  localparam int unsigned CNT_W = (RCLK_HALF > 1) ? $clog2(RCLK_HALF) : 1;

  rclk_phase_e      phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rclk_q;
  logic             cnt_last;

  assign cnt_last  = (cnt_q == CNT_W'(RCLK_HALF - 1));
  assign hi_last_o = (phase_q == G_HI) && cnt_last;
  assign lo_last_o = (phase_q == G_LO) && cnt_last;
  assign rclk_o    = rclk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= G_IDLE;
      cnt_q   <= '0;
      rclk_q  <= 1'b0;
    end else if (start_i) begin
      phase_q <= G_HI;
      cnt_q   <= '0;
      rclk_q  <= 1'b1;
    end else begin
      case (phase_q)
        G_HI: begin
          if (cnt_last) begin
            phase_q <= G_LO;
            cnt_q   <= '0;
            rclk_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        G_LO: begin
          if (cnt_last) begin
            phase_q <= G_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          phase_q <= G_IDLE;
          cnt_q   <= '0;
          rclk_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_fifo_reader.sv
// Captures one camera frame into an external FIFO, then streams a cropped window out.
// Optional CR/LF frame trailer enabled by defining FRAME_TRAILER_EN.
module frame_fifo_reader
  import frame_pkg::*;
#(
  parameter int unsigned FRAME_W   = 320,
  parameter int unsigned FRAME_H   = 240,
  parameter int unsigned BPP       = 2,
  parameter int unsigned RCLK_HALF = 2
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       vsync,
  input  logic [7:0]                 fifo_d,
  output logic                       fifo_wen,
  output logic                       fifo_wrst,
  output logic                       fifo_rclk,
  output logic                       fifo_rrst,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [$clog2(FRAME_W):0]   crop_x0,
  input  logic [$clog2(FRAME_W):0]   crop_w,
  input  logic [$clog2(FRAME_H):0]   crop_y0,
  input  logic [$clog2(FRAME_H):0]   crop_h,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int unsigned CW = $clog2(FRAME_W) + 1;
  localparam int unsigned CH = $clog2(FRAME_H) + 1;

  state_e                      state_q;
  logic [VSYNC_SYNC_DEPTH-1:0] vs_sync_q;
  logic                        vs_hist_q;
  logic                        fifo_wen_q, fifo_wrst_q, fifo_rrst_q;
  logic [7:0]                  m_data_q;
  logic                        m_valid_q, frame_done_q, overrun_q, end_q;
  logic [CW-1:0]               x_q, cx0_q, cw_q;
  logic [CH-1:0]               y_q, cy0_q, ch_q;
  logic [1:0]                  byte_q;

  logic vsync_rise, hi_last, lo_last, gen_start, hs, in_win, last_pix, sample;
  logic [CW:0] x_end;
  logic [CH:0] y_end;

  assign vsync_rise = vs_sync_q[VSYNC_SYNC_DEPTH-1] & ~vs_hist_q;
  assign hs         = m_valid_q & m_ready;
  assign sample     = (state_q == S_RD_LO) && lo_last;

  // One extra bit on the window end so x0+w past the frame edge cannot wrap.
  always_comb begin
    x_end    = {1'b0, cx0_q} + {1'b0, cw_q};
    y_end    = {1'b0, cy0_q} + {1'b0, ch_q};
    in_win   = (x_q >= cx0_q) && ({1'b0, x_q} < x_end) &&
               (y_q >= cy0_q) && ({1'b0, y_q} < y_end);
    last_pix = (byte_q == 2'(BPP - 1)) && (x_q == CW'(FRAME_W - 1)) &&
               (y_q == CH'(FRAME_H - 1));
    gen_start = ((state_q == S_CAPT) && vsync_rise) ||
                ((state_q == S_RRST) && lo_last) ||
                (sample && !in_win && !last_pix) ||
                ((state_q == S_EMIT) && hs && !end_q);
  end

  fifo_rclk_gen #(.RCLK_HALF(RCLK_HALF)) u_rclk (
    .clk_i     (sys_clk),
    .rst_i     (rst),
    .start_i   (gen_start),
    .rclk_o    (fifo_rclk),
    .hi_last_o (hi_last),
    .lo_last_o (lo_last)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vs_sync_q    <= '0;
      vs_hist_q    <= 1'b0;
      fifo_wen_q   <= 1'b0;
      fifo_wrst_q  <= 1'b1;
      fifo_rrst_q  <= 1'b1;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      end_q        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      byte_q       <= '0;
      cx0_q        <= '0;
      cw_q         <= '0;
      cy0_q        <= '0;
      ch_q         <= '0;
    end else begin
      vs_sync_q    <= {vs_sync_q[VSYNC_SYNC_DEPTH-2:0], vsync};
      vs_hist_q    <= vs_sync_q[VSYNC_SYNC_DEPTH-1];
      frame_done_q <= 1'b0;
      if (vsync_rise && (state_q inside {S_RRST, S_RD_HI, S_RD_LO, S_EMIT, S_TRL0, S_TRL1}))
        overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: if (start || continuous) state_q <= S_ARM;
        S_ARM: if (vsync_rise) begin
          fifo_wrst_q <= 1'b0;
          state_q     <= S_WRST;
        end
        S_WRST: begin
          fifo_wrst_q <= 1'b1;
          fifo_wen_q  <= 1'b1;
          state_q     <= S_CAPT;
        end
        S_CAPT: if (vsync_rise) begin
          fifo_wen_q  <= 1'b0;
          fifo_rrst_q <= 1'b0;
          cx0_q       <= crop_x0;
          cw_q        <= crop_w;
          cy0_q       <= crop_y0;
          ch_q        <= crop_h;
          x_q         <= '0;
          y_q         <= '0;
          byte_q      <= '0;
          end_q       <= 1'b0;
          state_q     <= S_RRST;
        end
        S_RRST: if (lo_last) begin
          fifo_rrst_q <= 1'b1;
          state_q     <= S_RD_HI;
        end
        S_RD_HI: if (hi_last) state_q <= S_RD_LO;
        S_RD_LO: if (lo_last) begin
          end_q <= last_pix;
          if (byte_q == 2'(BPP - 1)) begin
            byte_q <= '0;
            if (x_q == CW'(FRAME_W - 1)) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end else begin
            byte_q <= byte_q + 1'b1;
          end
          if (in_win) begin
            m_data_q  <= fifo_d;
            m_valid_q <= 1'b1;
            state_q   <= S_EMIT;
          end else if (last_pix) begin
`ifdef FRAME_TRAILER_EN
            m_data_q  <= TRAILER_CR;
            m_valid_q <= 1'b1;
            state_q   <= S_TRL0;
`else
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
`endif
          end else begin
            state_q <= S_RD_HI;
          end
        end
        S_EMIT: if (hs) begin
          if (end_q) begin
`ifdef FRAME_TRAILER_EN
            m_data_q <= TRAILER_CR;
            state_q  <= S_TRL0;
`else
            m_valid_q    <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
`endif
          end else begin
            m_valid_q <= 1'b0;
            state_q   <= S_RD_HI;
          end
        end
`ifdef FRAME_TRAILER_EN
        S_TRL0: if (hs) begin
          m_data_q <= TRAILER_LF;
          state_q  <= S_TRL1;
        end
        S_TRL1: if (hs) begin
          m_valid_q    <= 1'b0;
          frame_done_q <= 1'b1;
          state_q      <= S_DONE;
        end
`endif
        S_DONE: state_q <= continuous ? S_ARM : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_wen   = fifo_wen_q;
  assign fifo_wrst  = fifo_wrst_q;
  assign fifo_rrst  = fifo_rrst_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_fifo_reader.sv
// Directed bench for frame_fifo_reader on a 4x2 frame, 2 bytes/pixel, FIFO holding 0x00..0x0F.
module tb_frame_fifo_reader;

  logic       sys_clk = 1'b0;
  logic       rst, vsync, start, continuous, m_ready;
  logic [7:0] fifo_d;
  logic       fifo_wen, fifo_wrst, fifo_rclk, fifo_rrst;
  logic [2:0] crop_x0, crop_w;
  logic [1:0] crop_y0, crop_h;
  logic [7:0] m_data;
  logic       m_valid, busy, frame_done, overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q[$];
  int         done_cnt, stab_err;
  bit         finished;
  int         rptr = 0;
  logic       rclk_prev = 1'b0;

  always #5 sys_clk = ~sys_clk;

  frame_fifo_reader #(.FRAME_W(4), .FRAME_H(2), .BPP(2), .RCLK_HALF(2)) dut (
    .sys_clk(sys_clk), .rst(rst), .vsync(vsync), .fifo_d(fifo_d),
    .fifo_wen(fifo_wen), .fifo_wrst(fifo_wrst), .fifo_rclk(fifo_rclk), .fifo_rrst(fifo_rrst),
    .start(start), .continuous(continuous),
    .crop_x0(crop_x0), .crop_w(crop_w), .crop_y0(crop_y0), .crop_h(crop_h),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  // FIFO read side: pointer cleared by rrst, next byte presented on each rclk rise.
  always @(negedge sys_clk) begin
    if (fifo_rrst !== 1'b1) rptr = 0;
    else if (fifo_rclk === 1'b1 && rclk_prev === 1'b0) begin
      fifo_d = 8'(rptr);
      rptr   = rptr + 1;
    end
    rclk_prev = fifo_rclk;
  end

  task automatic arm_and_capture();
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    repeat (2) @(negedge sys_clk);
    vsync = 1'b1;
    repeat (3) @(negedge sys_clk);
    vsync = 1'b0;
    repeat (6) @(negedge sys_clk);
    vsync = 1'b1;
    repeat (3) @(negedge sys_clk);
    vsync = 1'b0;
  endtask

  task automatic do_frame(input int pct, input int inject);
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    int         extra = -1;
    got_q.delete();
    done_cnt = 0;
    stab_err = 0;
    finished = 1'b0;
    arm_and_capture();
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (inject >= 0 && i == inject) vsync = 1'b1;
      if (inject >= 0 && i == inject + 3) vsync = 1'b0;
      m_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stab_err++;
      if (m_valid && m_ready) got_q.push_back(m_data);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (extra < 0) extra = 10;
      end
      if (extra == 0) begin
        finished = 1'b1;
        break;
      end
      if (extra > 0) extra--;
    end
    m_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk) rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 8'h00)    begin bad++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (fifo_wen !== 1'b0)   begin bad++; $display("FAIL reset_wen got=%b exp=0", fifo_wen); end
    total++; if (fifo_wrst !== 1'b1)  begin bad++; $display("FAIL reset_wrst got=%b exp=1", fifo_wrst); end
    total++; if (fifo_rrst !== 1'b1)  begin bad++; $display("FAIL reset_rrst got=%b exp=1", fifo_rrst); end
    total++; if (fifo_rclk !== 1'b0)  begin bad++; $display("FAIL reset_rclk got=%b exp=0", fifo_rclk); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_wrst_capt();
    int wrst_low = 0;
    int k;
    crop_x0 = 3'd0; crop_w = 3'd4; crop_y0 = 2'd0; crop_h = 2'd2;
    m_ready = 1'b1;
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    @(negedge sys_clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL arm_busy got=%b exp=1", busy); end
    total++; if (fifo_wen !== 1'b0) begin bad++; $display("FAIL arm_wen got=%b exp=0", fifo_wen); end
    vsync = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (fifo_wrst === 1'b0) wrst_low++;
    end
    total++; if (wrst_low != 1) begin bad++; $display("FAIL wrst_pulse_len got=%0d exp=1", wrst_low); end
    total++; if (fifo_wen !== 1'b1) begin bad++; $display("FAIL capt_wen got=%b exp=1", fifo_wen); end
    vsync = 1'b0;
    repeat (4) @(negedge sys_clk);
    total++; if (fifo_wen !== 1'b1) begin bad++; $display("FAIL capt_wen_hold got=%b exp=1", fifo_wen); end
    vsync = 1'b1;
    repeat (4) @(negedge sys_clk);
    vsync = 1'b0;
    total++; if (fifo_wen !== 1'b0) begin bad++; $display("FAIL capt_end_wen got=%b exp=0", fifo_wen); end
    k = 0;
    while (busy === 1'b1 && k < 500) begin
      @(negedge sys_clk);
      k++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0 (timeout)", busy); end
  endtask

  task automatic test_full_frame();
    logic [7:0] exp_q[$];
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
`ifdef FRAME_TRAILER_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    crop_x0 = 3'd0; crop_w = 3'd4; crop_y0 = 2'd0; crop_h = 2'd2;
    do_frame(100, -1);
    total++; if (!finished) begin bad++; $display("FAIL full_timeout got=0 exp=1"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done_count got=%0d exp=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_end_busy got=%b exp=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL full_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_crop();
    int cx0[4]   = '{1, 0, 3, 0};
    int cw[4]    = '{2, 0, 4, 4};
    int cy0[4]   = '{1, 0, 1, 0};
    int chh[4]   = '{1, 2, 3, 0};
    int first[4] = '{10, 0, 14, 0};
    int cnt[4]   = '{4, 0, 2, 0};
    for (int c = 0; c < 4; c++) begin
      logic [7:0] exp_q[$];
      for (int i = 0; i < cnt[c]; i++) exp_q.push_back(8'(first[c] + i));
`ifdef FRAME_TRAILER_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
      crop_x0 = 3'(cx0[c]); crop_w = 3'(cw[c]); crop_y0 = 2'(cy0[c]); crop_h = 2'(chh[c]);
      do_frame(100, -1);
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL crop%0d_count got=%0d exp=%0d", c, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL crop%0d_byte[%0d] got=%h exp=%h", c, i, got_q[i], exp_q[i]); end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL crop%0d_done_count got=%0d exp=1", c, done_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
`ifdef FRAME_TRAILER_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    crop_x0 = 3'd0; crop_w = 3'd4; crop_y0 = 2'd0; crop_h = 2'd2;
    do_frame(30, -1);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stall_stability got=%0d exp=0", stab_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_overrun_continuous();
    int nexp;
`ifdef FRAME_TRAILER_EN
    nexp = 18;
`else
    nexp = 16;
`endif
    crop_x0 = 3'd0; crop_w = 3'd4; crop_y0 = 2'd0; crop_h = 2'd2;
    continuous = 1'b1;
    do_frame(100, 20);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    total++; if (got_q.size() != nexp) begin bad++; $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), nexp); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== 8'(i)) begin bad++; $display("FAIL ovr_byte[%0d] got=%h exp=%h", i, got_q[i], 8'(i)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ovr_done_count got=%0d exp=1", done_cnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cont_rearm_busy got=%b exp=1", busy); end
    continuous = 1'b0;
    pulse_reset();
    @(negedge sys_clk);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_cleared_by_reset got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_in_emit();
    int k = 0;
    crop_x0 = 3'd0; crop_w = 3'd4; crop_y0 = 2'd0; crop_h = 2'd2;
    m_ready = 1'b0;
    arm_and_capture();
    while (m_valid !== 1'b1 && k < 500) begin
      @(negedge sys_clk);
      k++;
    end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL emit_reach got=%b exp=1 (timeout)", m_valid); end
    rst = 1'b1;
    @(negedge sys_clk);
    total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL rst_emit_valid got=%b exp=0", m_valid); end
    total++; if (fifo_wen !== 1'b0)  begin bad++; $display("FAIL rst_emit_wen got=%b exp=0", fifo_wen); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_emit_busy got=%b exp=0", busy); end
    total++; if (fifo_rclk !== 1'b0) begin bad++; $display("FAIL rst_emit_rclk got=%b exp=0", fifo_rclk); end
    total++; if (m_data !== 8'h00)   begin bad++; $display("FAIL rst_emit_data got=%h exp=00", m_data); end
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_emit_no_trailer got=%b exp=0", m_valid); end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; start = 1'b0; continuous = 1'b0; m_ready = 1'b1;
    fifo_d = 8'h00;
    crop_x0 = '0; crop_w = '0; crop_y0 = '0; crop_h = '0;
    test_reset();
    test_wrst_capt();
    test_full_frame();
    test_crop();
    test_backpressure();
    test_overrun_continuous();
    test_reset_in_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
